bus_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream WIDTH-bit bus, built from the team's mux tree, among N_REQ requesters. It owns the mux select, grants one requester at a time with burst locking, and forwards a valid/ready handshake between the granted requester and the shared sink. It sits between the CPU-side masters (CPU, screen refresh, keyboard DMA) and the shared RAM port.

---
 rtl/bus_arb_pkg.sv | 18 +
 rtl/bus_arbiter_if.sv | 34 +++
 rtl/bus_arbiter_rr_pick.sv | 35 +++
 rtl/bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_bus_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and sizing helpers for the round-robin bus arbiter.
package bus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_N_REQ   = 4;
  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned DEF_TIMEOUT = 15;

  // Width of an index into n requesters (at least one bit).
  function automatic int unsigned sel_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester/sink handshake bundle shared by the arbiter and its environment.
interface bus_arbiter_if
  import bus_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  localparam int unsigned SEL_W = sel_w(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       grant;
  logic [SEL_W-1:0]       sel;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic                   out_ready;
  logic                   timeout;

  // Arbiter side: owns grant, select and the forwarded handshake.
  modport master (
    input  req_valid, req_last, req_data, out_ready,
    output req_ready, grant, sel, out_valid, out_data, timeout
  );

  // Environment side: requesters and the shared sink.
  modport slave (
    output req_valid, req_last, req_data, out_ready,
    input  req_ready, grant, sel, out_valid, out_data, timeout
  );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first request found after ptr, wrapping.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  localparam int unsigned SEL_W = sel_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic             found;
  logic [SEL_W-1:0] cand;

  // Scan ptr+1 .. ptr+N_REQ so ptr itself is considered last.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    any    = |req;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = SEL_W'((32'(ptr) + k) % N_REQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter with burst locking over a shared valid/ready sink.
// Optional stall timeout is built when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = DEF_N_REQ,
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input logic          clk,
  input logic          rst_n,
  bus_arbiter_if.master bus
);

  localparam int unsigned SEL_W = sel_w(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_cfg_check
    $error("bus_arbiter: N_REQ must be 2..8 and TIMEOUT at least 1");
  end

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             xfer, force_rel, rel;
  logic [N_REQ-1:0] pick_req, win_oh;
  logic [SEL_W-1:0] pick_ptr, win_idx;
  logic             win_any;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             timeout_q, timeout_d;
`endif

  // Forward the owner's handshake and data; nothing passes while idle.
  always_comb begin
    bus.out_valid = (state_q == BUSY) && bus.req_valid[sel_q];
    bus.out_data  = bus.req_data[32'(sel_q)*WIDTH +: WIDTH];
    bus.req_ready = '0;
    if (state_q == BUSY) bus.req_ready[sel_q] = bus.out_ready;
    xfer = bus.out_valid && bus.out_ready;
`ifdef BUS_ARB_TIMEOUT_EN
    force_rel = (state_q == BUSY) && !bus.out_valid && (stall_q == CNT_W'(TIMEOUT - 1));
`else
    force_rel = 1'b0;
`endif
    rel = (state_q == BUSY) && ((xfer && bus.req_last[sel_q]) || force_rel);
  end

  // At release the search restarts after the owner, which is excluded.
  always_comb begin
    pick_req = bus.req_valid;
    pick_ptr = ptr_q;
    if (state_q == BUSY) begin
      pick_req[sel_q] = 1'b0;
      pick_ptr        = sel_q;
    end
  end

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (pick_req),
    .ptr    (pick_ptr),
    .onehot (win_oh),
    .idx    (win_idx),
    .any    (win_any)
  );

  // Next-state: grant on idle request, hand over or drop the bus at release.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
`ifdef BUS_ARB_TIMEOUT_EN
    stall_d   = '0;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = BUSY;
          grant_d = win_oh;
          sel_d   = win_idx;
        end
      end
      BUSY: begin
`ifdef BUS_ARB_TIMEOUT_EN
        stall_d = stall_q;
        if (xfer || rel) stall_d = '0;
        else if (!bus.out_valid) stall_d = stall_q + CNT_W'(1);
        timeout_d = force_rel;
`endif
        if (rel) begin
          ptr_d = sel_q;
          if (win_any) begin
            grant_d = win_oh;
            sel_d   = win_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and grant registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= SEL_W'(N_REQ - 1);
`ifdef BUS_ARB_TIMEOUT_EN
      stall_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
`ifdef BUS_ARB_TIMEOUT_EN
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
`ifdef BUS_ARB_TIMEOUT_EN
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: randomized requesters and sink against
// a queue-based reference model of the arbitration rules.
module tb_bus_arbiter;
  import bus_arb_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned TO = 15;
  localparam int unsigned SW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();
  bus_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { logic [W-1:0] data; logic last; } src_t;
  typedef struct { int id; logic [W-1:0] data; logic last; } beat_t;
  typedef struct { logic [N-1:0] grant; int sel; logic ov; logic [N-1:0] rr; logic to; } cyc_t;

  src_t  srcq [N][$];
  beat_t exp_beats[$];
  cyc_t  exp_cyc[$];

  int owner, ptr, stall;
  logic exp_to;
  int pv [N];
  int p_ready, p_new, max_len;
  logic [N-1:0] active;
  logic mon_en = 1'b0;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec rule: first requester after p, wrapping; -1 if none.
  function automatic int rr_scan(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    owner = -1; ptr = N - 1; stall = 0; exp_to = 1'b0;
    for (int i = 0; i < N; i++) srcq[i].delete();
    exp_beats.delete();
    exp_cyc.delete();
  endtask

  task automatic add_burst(input int i, input int len);
    src_t s;
    for (int b = 0; b < len; b++) begin
      s.data = W'($urandom);
      s.last = (b == len - 1);
      srcq[i].push_back(s);
    end
  endtask

  // One cycle per iteration: drive inputs, predict outputs, advance the model.
  task automatic run_cycles(input int n);
    logic [N-1:0] v, lst, m;
    logic [N*W-1:0] d;
    logic rdy, xfer, forced;
    cyc_t c;
    beat_t bt;
    src_t s;
    int w;
    repeat (n) begin
      for (int i = 0; i < N; i++)
        if (active[i] && srcq[i].size() == 0 && $urandom_range(99) < 32'(p_new))
          add_burst(i, 1 + int'($urandom_range(max_len - 1)));
      for (int i = 0; i < N; i++) begin
        v[i] = (srcq[i].size() > 0) && ($urandom_range(99) < 32'(pv[i]));
        if (srcq[i].size() > 0) begin
          lst[i] = srcq[i][0].last;
          d[i*W +: W] = srcq[i][0].data;
        end else begin
          lst[i] = 1'b0;
          d[i*W +: W] = W'($urandom);
        end
      end
      rdy = $urandom_range(99) < 32'(p_ready);
      bus.req_valid = v;
      bus.req_last  = lst;
      bus.req_data  = d;
      bus.out_ready = rdy;

      c.grant = (owner >= 0) ? (N'(1) << owner) : '0;
      c.sel   = owner;
      c.ov    = (owner >= 0) && v[owner];
      c.rr    = (owner >= 0 && rdy) ? (N'(1) << owner) : '0;
      c.to    = exp_to;
      exp_cyc.push_back(c);

      xfer = c.ov && rdy;
      if (xfer) begin
        s = srcq[owner].pop_front();
        bt.id = owner; bt.data = s.data; bt.last = s.last;
        exp_beats.push_back(bt);
      end

      exp_to = 1'b0;
      if (owner < 0) begin
        owner = rr_scan(v, ptr);
        stall = 0;
      end else begin
        forced = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
        if (xfer) stall = 0;
        else if (!v[owner]) begin
          if (stall == TO - 1) forced = 1'b1;
          else stall++;
        end
`endif
        if ((xfer && bt.last) || forced) begin
          ptr = owner;
          m = v;
          m[owner] = 1'b0;
          owner = rr_scan(m, ptr);
          exp_to = forced;
          stall = 0;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Monitor: per-cycle expectations every cycle, beats when the sink accepts.
  always @(negedge clk) begin
    cyc_t c;
    beat_t b;
    if (mon_en && exp_cyc.size() > 0) begin
      c = exp_cyc.pop_front();
      chk("grant", 32'(bus.grant), 32'(c.grant));
      if (c.grant != '0) chk("sel", 32'(bus.sel), 32'(c.sel));
      chk("out_valid", 32'(bus.out_valid), 32'(c.ov));
      chk("req_ready", 32'(bus.req_ready), 32'(c.rr));
      chk("timeout", 32'(bus.timeout), 32'(c.to));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_beats.size() == 0) begin
          chk("beat_unexpected", 32'(1), 32'(0));
        end else begin
          b = exp_beats.pop_front();
          chk("beat_src", 32'(bus.sel), 32'(b.id));
          chk("beat_data", 32'(bus.out_data), 32'(b.data));
        end
      end
    end
  end

  task automatic set_all_pv(input int p);
    for (int i = 0; i < N; i++) pv[i] = p;
  endtask

  initial begin
    int guard;
    model_reset();
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.out_ready = 1'b0;
    p_ready = 100; p_new = 0; max_len = 1; active = '0; set_all_pv(100);
    #1;
    chk("rst_grant", 32'(bus.grant), 32'(0));
    chk("rst_sel", 32'(bus.sel), 32'(0));
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_req_ready", 32'(bus.req_ready), 32'(0));
    chk("rst_timeout", 32'(bus.timeout), 32'(0));
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; mon_en = 1'b1;

    // Single requester, 3-beat burst, then back to idle.
    add_burst(2, 3);
    run_cycles(1);
    chk("single_grant", 32'(bus.grant), 32'h4);
    chk("single_sel", 32'(bus.sel), 32'd2);
    run_cycles(5);

    // Fairness: continuous 1-beat bursts from everyone.
    active = 4'b1111; p_new = 100; max_len = 1;
    run_cycles(20);
    active = '0; p_new = 0;
    run_cycles(4);

    // Lock: requester 0 arrives while requester 1 is mid-burst.
    add_burst(1, 4);
    run_cycles(2);
    add_burst(0, 2);
    run_cycles(8);

    // Backpressure: sink stalls for 5 cycles mid-burst.
    add_burst(3, 3);
    run_cycles(2);
    p_ready = 0;
    run_cycles(5);
    p_ready = 100;
    run_cycles(4);

`ifdef BUS_ARB_TIMEOUT_EN
    // Owner goes silent mid-burst while another requester waits.
    add_burst(1, 3);
    run_cycles(2);
    pv[1] = 0;
    add_burst(2, 1);
    run_cycles(TO + 6);
    pv[1] = 100;
    run_cycles(6);
`endif

    // Random traffic with stalls on both sides.
    active = 4'b1111; p_new = 30; max_len = 4; p_ready = 70; set_all_pv(75);
    run_cycles(2000);

    // Reset in the middle of a burst.
    guard = 0;
    while (owner < 0 && guard < 50) begin run_cycles(1); guard++; end
    chk("reset_owner_found", 32'(owner >= 0), 32'(1));
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_grant", 32'(bus.grant), 32'(0));
    chk("midrst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("midrst_req_ready", 32'(bus.req_ready), 32'(0));
    model_reset();
    active = '0; p_new = 0; p_ready = 100; set_all_pv(100);
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; mon_en = 1'b1;
    for (int i = 0; i < N; i++) add_burst(i, 2);
    run_cycles(1);
    chk("post_reset_first", 32'(bus.grant), 32'h1);
    run_cycles(12);

    chk("beats_drained", 32'(exp_beats.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
